// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and the stage-register record for the write-back block.
// Imported by wb_regfile and regfile_array.
package wb_regfile_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;
   localparam int RegNumLog2 = 5;

   localparam logic [RegBus-1:0]     ZeroWord    = '0;
   localparam logic                  RstEnable   = 1'b1;
   localparam logic                  WriteEnable = 1'b1;
   localparam logic [RegAddrBus-1:0] NOPRegAddr  = 5'b00000;

   typedef struct packed {
      logic [RegAddrBus-1:0] wd;
      logic                  wreg;
      logic [RegBus-1:0]     wdata;
   } stage_t;

   localparam stage_t Bubble = '{wd: NOPRegAddr, wreg: 1'b0, wdata: ZeroWord};

   function automatic logic stage_hit(input stage_t s, input logic [RegAddrBus-1:0] raddr);
      return (s.wreg == WriteEnable) && (s.wd == raddr);
   endfunction

endpackage

// File: rtl/regfile_array.sv
// 32x32 register storage: one synchronous write port, two asynchronous read ports.
// Synchronous reset clears every entry; entry 0 is never written.
module regfile_array
   import wb_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [RegNumLog2-1:0] waddr_i,
   input  logic [RegBus-1:0]     wdata_i,
   input  logic [RegNumLog2-1:0] raddr1_i,
   input  logic [RegNumLog2-1:0] raddr2_i,
   output logic [RegBus-1:0]     rdata1_o,
   output logic [RegBus-1:0]     rdata2_o
);

   logic [RegBus-1:0] mem_q [RegNum];

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         for (int i = 0; i < RegNum; i++) begin
            mem_q[i] <= ZeroWord;
         end
      end else if ((we_i == WriteEnable) && (waddr_i != NOPRegAddr)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = mem_q[raddr1_i];
   assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// EX/MEM and MEM/WB stage registers, register-file commit and decode read ports.
// WB_BYPASS_EN selects forwarding from in-flight stages; otherwise a RAW hazard raises stallreq_o.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic [RegAddrBus-1:0] ex_wd_i,
   input  logic                  ex_wreg_i,
   input  logic [RegBus-1:0]     ex_wdata_i,
   input  logic                  re1_i,
   input  logic                  re2_i,
   input  logic [RegAddrBus-1:0] raddr1_i,
   input  logic [RegAddrBus-1:0] raddr2_i,
   output logic [RegBus-1:0]     rdata1_o,
   output logic [RegBus-1:0]     rdata2_o,
   output logic                  stallreq_o,
   output logic [RegAddrBus-1:0] mem_wd_o,
   output logic                  mem_wreg_o,
   output logic [RegBus-1:0]     mem_wdata_o,
   output logic [RegAddrBus-1:0] wb_wd_o,
   output logic                  wb_wreg_o,
   output logic [RegBus-1:0]     wb_wdata_o
);

   stage_t            ex_in;
   stage_t            ex_mem_q, ex_mem_d;
   stage_t            mem_wb_q, mem_wb_d;
   logic              commit_we;
   logic [RegBus-1:0] arr_rdata1, arr_rdata2;

   assign ex_in = '{wd: ex_wd_i, wreg: ex_wreg_i, wdata: ex_wdata_i};

   always_comb begin
      ex_mem_d = ex_mem_q;
      mem_wb_d = mem_wb_q;
      if (flush_i) begin
         ex_mem_d = Bubble;
         mem_wb_d = Bubble;
      end else if (!stall_i) begin
         ex_mem_d = ex_in;
         mem_wb_d = ex_mem_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         ex_mem_q <= Bubble;
         mem_wb_q <= Bubble;
      end else begin
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   // Commit is independent of stall/flush: rewriting the held MEM/WB value is harmless.
   assign commit_we = (mem_wb_q.wreg == WriteEnable) && (mem_wb_q.wd != NOPRegAddr);

   regfile_array u_array (
      .clk      (clk),
      .rst      (rst),
      .we_i     (commit_we),
      .waddr_i  (mem_wb_q.wd),
      .wdata_i  (mem_wb_q.wdata),
      .raddr1_i (raddr1_i),
      .raddr2_i (raddr2_i),
      .rdata1_o (arr_rdata1),
      .rdata2_o (arr_rdata2)
   );

   function automatic logic [RegBus-1:0] read_port(
      input logic                  rst_v,
      input logic                  re,
      input logic [RegAddrBus-1:0] raddr,
      input logic [RegBus-1:0]     arr,
      input stage_t                ex,
      input stage_t                em,
      input stage_t                mw
   );
      if ((rst_v == RstEnable) || !re || (raddr == NOPRegAddr)) begin
         return ZeroWord;
      end
`ifdef WB_BYPASS_EN
      if (stage_hit(ex, raddr)) return ex.wdata;
      if (stage_hit(em, raddr)) return em.wdata;
      if (stage_hit(mw, raddr)) return mw.wdata;
`else
      if (stage_hit(ex, raddr) || stage_hit(em, raddr) || stage_hit(mw, raddr)) begin
         return arr;
      end
`endif
      return arr;
   endfunction

   assign rdata1_o = read_port(rst, re1_i, raddr1_i, arr_rdata1, ex_in, ex_mem_q, mem_wb_q);
   assign rdata2_o = read_port(rst, re2_i, raddr2_i, arr_rdata2, ex_in, ex_mem_q, mem_wb_q);

`ifdef WB_BYPASS_EN
   assign stallreq_o = 1'b0;
`else
   function automatic logic hazard(
      input logic                  re,
      input logic [RegAddrBus-1:0] raddr,
      input stage_t                ex,
      input stage_t                em,
      input stage_t                mw
   );
      return re && (raddr != NOPRegAddr) &&
             (stage_hit(ex, raddr) || stage_hit(em, raddr) || stage_hit(mw, raddr));
   endfunction

   assign stallreq_o = (rst != RstEnable) &&
                       (hazard(re1_i, raddr1_i, ex_in, ex_mem_q, mem_wb_q) ||
                        hazard(re2_i, raddr2_i, ex_in, ex_mem_q, mem_wb_q));
`endif

   assign mem_wd_o    = ex_mem_q.wd;
   assign mem_wreg_o  = ex_mem_q.wreg;
   assign mem_wdata_o = ex_mem_q.wdata;
   assign wb_wd_o     = mem_wb_q.wd;
   assign wb_wreg_o   = mem_wb_q.wreg;
   assign wb_wdata_o  = mem_wb_q.wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expected values are hand-derived and depend on
// whether WB_BYPASS_EN is defined for the build.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i;
   logic [4:0]  ex_wd_i;
   logic        ex_wreg_i;
   logic [31:0] ex_wdata_i;
   logic        re1_i, re2_i;
   logic [4:0]  raddr1_i, raddr2_i;
   logic [31:0] rdata1_o, rdata2_o;
   logic        stallreq_o;
   logic [4:0]  mem_wd_o, wb_wd_o;
   logic        mem_wreg_o, wb_wreg_o;
   logic [31:0] mem_wdata_o, wb_wdata_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .ex_wd_i     (ex_wd_i),
      .ex_wreg_i   (ex_wreg_i),
      .ex_wdata_i  (ex_wdata_i),
      .re1_i       (re1_i),
      .re2_i       (re2_i),
      .raddr1_i    (raddr1_i),
      .raddr2_i    (raddr2_i),
      .rdata1_o    (rdata1_o),
      .rdata2_o    (rdata2_o),
      .stallreq_o  (stallreq_o),
      .mem_wd_o    (mem_wd_o),
      .mem_wreg_o  (mem_wreg_o),
      .mem_wdata_o (mem_wdata_o),
      .wb_wd_o     (wb_wd_o),
      .wb_wreg_o   (wb_wreg_o),
      .wb_wdata_o  (wb_wdata_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sel(input logic [31:0] byp_val, input logic [31:0] nobyp_val);
      return BYP ? byp_val : nobyp_val;
   endfunction

   // Inputs change 1 time unit after the rising edge, outputs are sampled 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      ex_wd_i    = wd;
      ex_wreg_i  = wreg;
      ex_wdata_i = wdata;
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive_ex(5'd0, 1'b0, 32'h0);
      re1_i = 1'b1; raddr1_i = 5'd5;
      re2_i = 1'b1; raddr2_i = 5'd31;

      // reset held for two edges
      #3;
      chk("rst_read_gate", rdata1_o, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #2;
      chk("rst_r5", rdata1_o, 32'h0);
      chk("rst_r31", rdata2_o, 32'h0);
      chk("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
      chk("rst_mem", {mem_wd_o, mem_wreg_o, mem_wdata_o[25:0]} | {6'h0, mem_wdata_o[31:26]}, 32'h0);
      chk("rst_wb_wd", {27'h0, wb_wd_o}, 32'h0);
      chk("rst_wb_wreg", {31'h0, wb_wreg_o}, 32'h0);
      chk("rst_wb_wdata", wb_wdata_o, 32'h0);

      // r3 = 0x1234 through the pipe
      next_cycle();
      drive_ex(5'd3, 1'b1, 32'h0000_1234);
      raddr1_i = 5'd3; raddr2_i = 5'd3;
      #2;
      chk("r3_t_rd", rdata1_o, sel(32'h1234, 32'h0));
      chk("r3_t_stall", {31'h0, stallreq_o}, {31'h0, !BYP});
      next_cycle();
      drive_ex(5'd0, 1'b0, 32'h0);
      #2;
      chk("r3_t1_mem_wd", {27'h0, mem_wd_o}, 32'd3);
      chk("r3_t1_mem_wreg", {31'h0, mem_wreg_o}, 32'd1);
      chk("r3_t1_mem_wdata", mem_wdata_o, 32'h1234);
      chk("r3_t1_rd", rdata1_o, sel(32'h1234, 32'h0));
      chk("r3_t1_stall", {31'h0, stallreq_o}, {31'h0, !BYP});
      next_cycle();
      #2;
      chk("r3_t2_wb_wd", {27'h0, wb_wd_o}, 32'd3);
      chk("r3_t2_wb_wdata", wb_wdata_o, 32'h1234);
      chk("r3_t2_rd", rdata2_o, sel(32'h1234, 32'h0));
      chk("r3_t2_stall", {31'h0, stallreq_o}, {31'h0, !BYP});
      next_cycle();
      #2;
      chk("r3_t3_rd1", rdata1_o, 32'h1234);
      chk("r3_t3_rd2", rdata2_o, 32'h1234);
      chk("r3_t3_stall", {31'h0, stallreq_o}, 32'h0);

      // newest wins on r4
      next_cycle();
      drive_ex(5'd4, 1'b1, 32'd1);
      raddr1_i = 5'd4; raddr2_i = 5'd4;
      #2;
      chk("r4_t_rd", rdata1_o, sel(32'd1, 32'd0));
      chk("r4_t_stall", {31'h0, stallreq_o}, {31'h0, !BYP});
      next_cycle();
      drive_ex(5'd4, 1'b1, 32'd2);
      #2;
      chk("r4_t1_rd", rdata1_o, sel(32'd2, 32'd0));
      chk("r4_t1_rd2", rdata2_o, sel(32'd2, 32'd0));
      next_cycle();
      drive_ex(5'd0, 1'b0, 32'h0);
      #2;
      chk("r4_t2_rd", rdata1_o, sel(32'd2, 32'd0));
      chk("r4_t2_stall", {31'h0, stallreq_o}, {31'h0, !BYP});
      next_cycle();
      #2;
      chk("r4_t3_rd", rdata1_o, sel(32'd2, 32'd1));
      chk("r4_t3_stall", {31'h0, stallreq_o}, {31'h0, !BYP});
      next_cycle();
      #2;
      chk("r4_t4_rd", rdata1_o, 32'd2);
      chk("r4_t4_stall", {31'h0, stallreq_o}, 32'h0);
      next_cycle();
      #2;
      chk("r4_t5_rd2", rdata2_o, 32'd2);

      // r0 write attempt
      next_cycle();
      drive_ex(5'd0, 1'b1, 32'hFFFF_FFFF);
      raddr1_i = 5'd0; raddr2_i = 5'd0;
      #2;
      chk("r0_t_rd", rdata1_o, 32'h0);
      chk("r0_t_stall", {31'h0, stallreq_o}, 32'h0);
      next_cycle();
      drive_ex(5'd0, 1'b0, 32'h0);
      #2;
      chk("r0_t1_mem_wdata", mem_wdata_o, 32'hFFFF_FFFF);
      chk("r0_t1_rd", rdata2_o, 32'h0);
      next_cycle();
      #2;
      chk("r0_t2_wb_wreg", {31'h0, wb_wreg_o}, 32'd1);
      chk("r0_t2_rd", rdata1_o, 32'h0);
      next_cycle();
      #2;
      chk("r0_t3_rd", rdata1_o, 32'h0);

      // stall three cycles with r7 in EX/MEM, then flush
      next_cycle();
      drive_ex(5'd7, 1'b1, 32'h0000_00A5);
      raddr1_i = 5'd7;
      next_cycle();
      drive_ex(5'd0, 1'b0, 32'h0);
      stall_i = 1'b1;
      #2;
      chk("stall_t1_mem_wd", {27'h0, mem_wd_o}, 32'd7);
      chk("stall_t1_mem_wdata", mem_wdata_o, 32'hA5);
      chk("stall_t1_rd", rdata1_o, sel(32'hA5, 32'h0));
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         if (i == 2) begin
            flush_i = 1'b1;
         end
         #2;
         chk("stall_hold_mem_wd", {27'h0, mem_wd_o}, 32'd7);
         chk("stall_hold_mem_wreg", {31'h0, mem_wreg_o}, 32'd1);
         chk("stall_hold_mem_wdata", mem_wdata_o, 32'hA5);
         chk("stall_hold_wb_wreg", {31'h0, wb_wreg_o}, 32'd0);
      end
      chk("flush_pre_rd", rdata1_o, sel(32'hA5, 32'h0));
      next_cycle();
      flush_i = 1'b0; stall_i = 1'b0;
      #2;
      chk("flush_mem_wd", {27'h0, mem_wd_o}, 32'd0);
      chk("flush_mem_wreg", {31'h0, mem_wreg_o}, 32'd0);
      chk("flush_mem_wdata", mem_wdata_o, 32'd0);
      chk("flush_wb_wreg", {31'h0, wb_wreg_o}, 32'd0);
      chk("flush_wb_wdata", wb_wdata_o, 32'd0);
      chk("flush_r7_rd", rdata1_o, 32'd0);
      chk("flush_stall", {31'h0, stallreq_o}, 32'd0);

      // reset mid-operation discards r5 in flight and clears the array
      next_cycle();
      drive_ex(5'd5, 1'b1, 32'h55);
      raddr1_i = 5'd5; raddr2_i = 5'd3;
      next_cycle();
      drive_ex(5'd0, 1'b0, 32'h0);
      rst = 1'b1;
      #2;
      chk("rstmid_rd_gate", rdata1_o, 32'h0);
      chk("rstmid_stall", {31'h0, stallreq_o}, 32'h0);
      next_cycle();
      rst = 1'b0;
      #2;
      chk("rstmid_mem_wreg", {31'h0, mem_wreg_o}, 32'd0);
      chk("rstmid_r5", rdata1_o, 32'h0);
      chk("rstmid_r3_cleared", rdata2_o, 32'h0);
      next_cycle();
      next_cycle();
      #2;
      chk("rstmid_r5_late", rdata1_o, 32'h0);
      raddr2_i = 5'd4;
      #1;
      chk("rstmid_r4_cleared", rdata2_o, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
